// File: rtl/game_sequencer_if.sv
// Sequencer <-> renderer/datapath handshake: phase, pass request/done,
// commit/init strobes and the datapath values the sequencer consumes.
interface game_sequencer_if;
  logic [1:0]  statesig;
  logic        draw_req;
  logic        draw_done;
  logic        commit;
  logic        init;
  logic [7:0]  ball_y;
  logic [15:0] next_score;

  modport master (
    output statesig, draw_req, commit, init,
    input  draw_done, ball_y, next_score
  );

  modport slave (
    input  statesig, draw_req, commit, init,
    output draw_done, ball_y, next_score
  );
endinterface

// File: rtl/game_sequencer.sv
// Frame-paced game sequencer: erase -> update -> commit -> draw each frame tick,
// with score/high-score tracking and a timed game-over hold.
module game_sequencer #(
  parameter int unsigned FRAME_DIV   = 833333,
  parameter int unsigned FLOOR_Y     = 116,
  parameter int unsigned OVER_FRAMES = 120
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_n,
  game_sequencer_if.master   bus,
  output logic [15:0]        score,
  output logic [15:0]        high_score,
  output logic               playing
);

  localparam int unsigned CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int unsigned OVR_W = (OVER_FRAMES > 1) ? $clog2(OVER_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_DIV - 1);
  localparam logic [OVR_W-1:0] OVR_LAST = OVR_W'(OVER_FRAMES - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT,
    S_ERASE,
    S_WAIT_E,
    S_UPDATE,
    S_COMMIT,
    S_DRAW,
    S_WAIT_D,
    S_WAIT_T,
    S_OVER
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [OVR_W-1:0] over_cnt_q, over_cnt_d;
  logic [15:0]      score_q, score_d;
  logic [15:0]      high_score_q, high_score_d;

  logic             tick;
  logic             floor_hit;
  logic [1:0]       statesig_c;
  logic             draw_req_c;
  logic             commit_c;
  logic             init_c;
  logic             playing_c;

  // Free-running frame divider; the tick is only consumed in WAIT_T and OVER.
  assign tick        = (frame_cnt_q == CNT_LAST);
  assign frame_cnt_d = tick ? '0 : frame_cnt_q + CNT_W'(1);

  assign floor_hit    = ({24'd0, bus.ball_y} >= FLOOR_Y);
  assign high_score_d = (score_q > high_score_q) ? score_q : high_score_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      frame_cnt_q  <= '0;
      over_cnt_q   <= '0;
      score_q      <= '0;
      high_score_q <= '0;
    end else begin
      state_q      <= state_d;
      frame_cnt_q  <= frame_cnt_d;
      over_cnt_q   <= over_cnt_d;
      score_q      <= score_d;
      high_score_q <= high_score_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    over_cnt_d = '0;
    score_d    = score_q;
    statesig_c = 2'b00;
    draw_req_c = 1'b0;
    commit_c   = 1'b0;
    init_c     = 1'b0;
    playing_c  = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        playing_c = 1'b0;
        if (!start_n) state_d = S_INIT;
      end
      S_INIT: begin
        init_c  = 1'b1;
        score_d = '0;
        state_d = S_DRAW;
      end
      S_ERASE: begin
        statesig_c = 2'b01;
        draw_req_c = 1'b1;
        state_d    = S_WAIT_E;
      end
      S_WAIT_E: begin
        statesig_c = 2'b01;
        if (bus.draw_done) state_d = S_UPDATE;
      end
      S_UPDATE: begin
        statesig_c = 2'b11;
        state_d    = S_COMMIT;
      end
      S_COMMIT: begin
        commit_c = 1'b1;
        score_d  = bus.next_score;
        state_d  = floor_hit ? S_OVER : S_DRAW;
      end
      S_DRAW: begin
        statesig_c = 2'b10;
        draw_req_c = 1'b1;
        state_d    = S_WAIT_D;
      end
      S_WAIT_D: begin
        statesig_c = 2'b10;
        if (bus.draw_done) state_d = S_WAIT_T;
      end
      S_WAIT_T: begin
        if (tick) state_d = S_ERASE;
      end
      S_OVER: begin
        // Hold for OVER_FRAMES ticks; start_n is deliberately not looked at here.
        playing_c  = 1'b0;
        over_cnt_d = over_cnt_q;
        if (tick) begin
          if (over_cnt_q == OVR_LAST) begin
            over_cnt_d = '0;
            state_d    = S_IDLE;
          end else begin
            over_cnt_d = over_cnt_q + OVR_W'(1);
          end
        end
      end
      default: begin
        playing_c = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  assign bus.statesig = statesig_c;
  assign bus.draw_req = draw_req_c;
  assign bus.commit   = commit_c;
  assign bus.init     = init_c;
  assign score        = score_q;
  assign high_score   = high_score_q;
  assign playing      = playing_c;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed vector table, random run against a
// behavioural model, and an asynchronous mid-pass reset sequence.
module tb_game_sequencer;
  localparam int FD = 8;
  localparam int FY = 116;
  localparam int OF = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_n;
  logic [15:0] score;
  logic [15:0] high_score;
  logic        playing;

  game_sequencer_if bus ();

  game_sequencer #(.FRAME_DIV(FD), .FLOOR_Y(FY), .OVER_FRAMES(OF)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_n    (start_n),
    .bus        (bus.master),
    .score      (score),
    .high_score (high_score),
    .playing    (playing)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        sn;
    logic        dd;
    logic [7:0]  by;
    logic [15:0] ns;
    logic [1:0]  ss;
    logic        dr;
    logic        cm;
    logic        in;
    logic [15:0] sc;
    logic [15:0] hs;
    logic        pl;
  } vec_t;

  vec_t vecs[$];

  function automatic void v(input int n, input bit sn, input bit dd, input int by, input int ns,
                            input int ss, input bit dr, input bit cm, input bit in,
                            input int sc, input int hs, input bit pl);
    vec_t r;
    r.sn = sn; r.dd = dd; r.by = 8'(by); r.ns = 16'(ns);
    r.ss = 2'(ss); r.dr = dr; r.cm = cm; r.in = in;
    r.sc = 16'(sc); r.hs = 16'(hs); r.pl = pl;
    for (int i = 0; i < n; i++) vecs.push_back(r);
  endfunction

  function automatic logic [37:0] outs();
    return {bus.statesig, bus.draw_req, bus.commit, bus.init, score, high_score, playing};
  endfunction

  task automatic check(input string name, input logic [37:0] act, input logic [37:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {ss,dr,cm,in,score,hs,pl}=%h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic sn, input logic dd, input logic [7:0] by, input logic [15:0] ns);
    start_n        = sn;
    bus.draw_done  = dd;
    bus.ball_y     = by;
    bus.next_score = ns;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b1, 1'b0, 8'd0, 16'd0);
    @(negedge clk);
    @(negedge clk);
    check("reset_state", outs(), 38'd0);
    reset = 1'b0;
  endtask

  // Behavioural model: game phases named after the game's behaviour, ticks
  // derived from the edge count since reset release.
  typedef enum int {P_IDLE, P_INIT, P_DRAW, P_WAIT_D, P_WAIT_T, P_ERASE, P_WAIT_E,
                    P_UPDATE, P_COMMIT, P_OVER} ph_t;
  ph_t         m_ph;
  logic [15:0] m_score, m_best;
  int          m_over_ticks, m_edge;

  function automatic logic [37:0] model_outs();
    logic [1:0] ss;
    ss = (m_ph == P_ERASE || m_ph == P_WAIT_E) ? 2'b01 :
         (m_ph == P_DRAW  || m_ph == P_WAIT_D) ? 2'b10 :
         (m_ph == P_UPDATE)                    ? 2'b11 : 2'b00;
    return {ss, (m_ph == P_ERASE || m_ph == P_DRAW), (m_ph == P_COMMIT), (m_ph == P_INIT),
            m_score, m_best, !(m_ph == P_IDLE || m_ph == P_OVER)};
  endfunction

  function automatic void model_edge(input logic sn, input logic dd, input logic [7:0] by,
                                     input logic [15:0] ns);
    bit          tick;
    logic [15:0] best_n;
    tick   = (m_edge % FD) == (FD - 1);
    best_n = (m_score > m_best) ? m_score : m_best;
    case (m_ph)
      P_IDLE:   if (!sn) m_ph = P_INIT;
      P_INIT:   begin m_score = 16'd0; m_ph = P_DRAW; end
      P_DRAW:   m_ph = P_WAIT_D;
      P_WAIT_D: if (dd) m_ph = P_WAIT_T;
      P_WAIT_T: if (tick) m_ph = P_ERASE;
      P_ERASE:  m_ph = P_WAIT_E;
      P_WAIT_E: if (dd) m_ph = P_UPDATE;
      P_UPDATE: m_ph = P_COMMIT;
      P_COMMIT: begin
        m_score = ns;
        if (int'(by) >= FY) begin m_ph = P_OVER; m_over_ticks = 0; end
        else m_ph = P_DRAW;
      end
      P_OVER: if (tick) begin
        m_over_ticks++;
        if (m_over_ticks == OF) m_ph = P_IDLE;
      end
      default: m_ph = P_IDLE;
    endcase
    m_best = best_n;
    m_edge++;
  endfunction

  initial begin
    int k;
    logic       sn, dd;
    logic [7:0] by;
    logic [15:0] ns;

    //  n  sn dd  by  ns  ss dr cm in  sc hs pl
    v(1,  0, 0,   0,  0,  0, 0, 0, 1,  0, 0, 1); // INIT
    v(1,  1, 0,   0,  0,  2, 1, 0, 0,  0, 0, 1); // DRAW
    v(2,  1, 0,   0,  0,  2, 0, 0, 0,  0, 0, 1); // WAIT_D
    v(1,  1, 1,   0,  0,  0, 0, 0, 0,  0, 0, 1); // WAIT_T
    v(1,  1, 0,   0,  0,  0, 0, 0, 0,  0, 0, 1);
    v(1,  1, 1,   0,  0,  0, 0, 0, 0,  0, 0, 1); // spurious done in WAIT_T
    v(1,  1, 0,   0,  0,  1, 1, 0, 0,  0, 0, 1); // tick -> ERASE
    v(1,  1, 0,   0,  0,  1, 0, 0, 0,  0, 0, 1);
    v(1,  1, 1,   0,  0,  3, 0, 0, 0,  0, 0, 1); // UPDATE
    v(1,  1, 0,   0,  0,  0, 0, 1, 0,  0, 0, 1); // COMMIT
    v(1,  1, 0,  50,  5,  2, 1, 0, 0,  5, 0, 1);
    v(1,  1, 0,   0,  0,  2, 0, 0, 0,  5, 5, 1); // high score lags
    v(3,  1, 0,   0,  0,  2, 0, 0, 0,  5, 5, 1); // tick in WAIT_D dropped
    v(1,  1, 1,   0,  0,  0, 0, 0, 0,  5, 5, 1);
    v(6,  1, 0,   0,  0,  0, 0, 0, 0,  5, 5, 1);
    v(1,  1, 0,   0,  0,  1, 1, 0, 0,  5, 5, 1);
    v(1,  1, 0,   0,  0,  1, 0, 0, 0,  5, 5, 1);
    v(1,  1, 1,   0,  0,  3, 0, 0, 0,  5, 5, 1);
    v(1,  1, 0,   0,  0,  0, 0, 1, 0,  5, 5, 1);
    v(1,  1, 0, 115,  9,  2, 1, 0, 0,  9, 5, 1); // 115: keep playing
    v(1,  1, 0,   0,  0,  2, 0, 0, 0,  9, 9, 1);
    v(1,  1, 1,   0,  0,  0, 0, 0, 0,  9, 9, 1);
    v(1,  1, 0,   0,  0,  0, 0, 0, 0,  9, 9, 1);
    v(1,  1, 0,   0,  0,  1, 1, 0, 0,  9, 9, 1);
    v(1,  1, 0,   0,  0,  1, 0, 0, 0,  9, 9, 1);
    v(1,  1, 1,   0,  0,  3, 0, 0, 0,  9, 9, 1);
    v(1,  1, 0,   0,  0,  0, 0, 1, 0,  9, 9, 1);
    v(1,  1, 0, 116,  3,  0, 0, 0, 0,  3, 9, 0); // 116: game over
    v(11, 0, 0,   0,  0,  0, 0, 0, 0,  3, 9, 0); // start ignored in OVER
    v(1,  1, 0,   0,  0,  0, 0, 0, 0,  3, 9, 0); // second tick -> IDLE
    v(1,  1, 1,   0,  0,  0, 0, 0, 0,  3, 9, 0); // spurious done in IDLE
    v(1,  0, 0,   0,  0,  0, 0, 0, 1,  3, 9, 1); // restart
    v(1,  1, 0,   0,  0,  2, 1, 0, 0,  0, 9, 1);

    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].sn, vecs[i].dd, vecs[i].by, vecs[i].ns);
      @(negedge clk);
      check($sformatf("vec%0d", i), outs(),
            {vecs[i].ss, vecs[i].dr, vecs[i].cm, vecs[i].in, vecs[i].sc, vecs[i].hs, vecs[i].pl});
    end

    // Random run against the model
    do_reset();
    m_ph = P_IDLE; m_score = 16'd0; m_best = 16'd0; m_over_ticks = 0; m_edge = 0;
    for (int c = 0; c < 3000; c++) begin
      sn = ($urandom_range(0, 7) != 0);
      dd = ($urandom_range(0, 3) == 0);
      by = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(112, 120)) : 8'($urandom);
      ns = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFFD, 16'hFFFF)) : 16'($urandom);
      drive(sn, dd, by, ns);
      model_edge(sn, dd, by, ns);
      @(negedge clk);
      check($sformatf("rand%0d", c), outs(), model_outs());
    end

    // Asynchronous reset while waiting for the erase pass
    do_reset();
    drive(1'b0, 1'b0, 8'd0, 16'd0);
    @(negedge clk);
    drive(1'b1, 1'b0, 8'd0, 16'd0);
    @(negedge clk);
    @(negedge clk);
    drive(1'b1, 1'b1, 8'd0, 16'd0);
    @(negedge clk);
    drive(1'b1, 1'b0, 8'd0, 16'd0);
    k = 0;
    while (bus.statesig !== 2'b01 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("reach_erase", {36'd0, bus.statesig}, {36'd0, 2'b01});
    @(negedge clk);
    check("in_wait_e", outs(), {2'b01, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b1});
    @(posedge clk);
    #3 reset = 1'b1;
    #1 check("async_reset", outs(), 38'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 1'b0, 8'd0, 16'd0);
    @(negedge clk);
    check("init_after_reset", outs(), {2'b00, 1'b0, 1'b0, 1'b1, 16'd0, 16'd0, 1'b1});
    drive(1'b1, 1'b0, 8'd0, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
